piso_serializer: RTL

//  Parallel-in/serial-out stage feeding the serial `in` of the 4-bit shift-register stage.

---
 rtl/piso_serializer_pkg.sv | 20 ++
 rtl/piso_serializer_if.sv | 11 +
 rtl/piso_hold_buf.sv | 55 +++++
 rtl/piso_serializer.sv | 123 ++++++++++++
 4 files changed

// File: rtl/piso_serializer_pkg.sv
// Shared types and helpers for the parallel-in/serial-out serializer.
package piso_serializer_pkg;

  // Shifter state: IDLE means no word is in the shifter.
  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  // Smallest usable bit-count width.
  localparam int MIN_CNT_W = 1;

  // Bit-count width for a given word width; never narrower than one bit.
  function automatic int cnt_width(input int width);
    int w;
    w = $clog2(width);
    return (w > MIN_CNT_W) ? w : MIN_CNT_W;
  endfunction

endpackage

// File: rtl/piso_serializer_if.sv
// Producer-side valid/ready word channel into the serializer.
interface piso_serializer_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] s_data;
  logic             s_valid;
  logic             s_ready;

  modport master (output s_data, output s_valid, input s_ready);
  modport slave  (input s_data, input s_valid, output s_ready);
endinterface

// File: rtl/piso_hold_buf.sv
// One-entry hold buffer between the producer handshake and the shifter.
// Ready is a flop so it never depends combinationally on valid or bit_en;
// a full buffer that drains on an edge cannot take a word on that same edge.
module piso_hold_buf #(
  parameter int WIDTH = 8
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_data,
  output logic             o_hb_valid
);
  import piso_serializer_pkg::*;

  logic [WIDTH-1:0] r_data;
  logic             r_hb_valid;
  logic             r_ready;
  logic             w_push;
  logic             w_hb_valid_nxt;

  // Next occupancy: a push fills, a pop drains; both cannot coincide.
  always_comb begin
    w_push         = i_valid && r_ready;
    w_hb_valid_nxt = r_hb_valid;
    if (w_push) begin
      w_hb_valid_nxt = 1'b1;
    end else if (i_pop) begin
      w_hb_valid_nxt = 1'b0;
    end else begin
      w_hb_valid_nxt = r_hb_valid;
    end
  end

  // Buffer storage, occupancy and registered ready.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_data     <= '0;
      r_hb_valid <= 1'b0;
      r_ready    <= 1'b0;
    end else begin
      r_hb_valid <= w_hb_valid_nxt;
      r_ready    <= !w_hb_valid_nxt;
      if (w_push) begin
        r_data <= i_data;
      end
    end
  end

  assign o_ready    = r_ready;
  assign o_data     = r_data;
  assign o_hb_valid = r_hb_valid;
endmodule

// File: rtl/piso_serializer.sv
// Parallel-in/serial-out serializer: takes WIDTH-bit words over valid/ready
// and emits one bit per bit_en cycle, reloading from the hold buffer on the
// last bit so consecutive words leave no idle bit between them.
module piso_serializer
  import piso_serializer_pkg::*;
#(
  parameter int   WIDTH      = 8,
  parameter bit   LSB_FIRST  = 1'b0,
  parameter logic IDLE_LEVEL = 1'b0
) (
  input  logic               i_clk,
  input  logic               i_reset,
  piso_serializer_if.slave   s_if,
  input  logic               i_bit_en,
  output logic               o_ser_out,
  output logic               o_ser_valid,
  output logic               o_ser_last,
  output logic               o_busy
);
  localparam int               CNT_W    = cnt_width(WIDTH);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  if (WIDTH < 2) begin : g_width_check
    $error("piso_serializer: WIDTH must be at least 2");
  end

  state_t           r_state;
  state_t           w_state_nxt;
  logic [WIDTH-1:0] r_sh;
  logic [WIDTH-1:0] w_sh_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             w_pop;
  logic [WIDTH-1:0] w_hb_data;
  logic             w_hb_valid;

  piso_hold_buf #(.WIDTH(WIDTH)) u_hold_buf (
    .i_clk      (i_clk),
    .i_reset    (i_reset),
    .i_data     (s_if.s_data),
    .i_valid    (s_if.s_valid),
    .o_ready    (s_if.s_ready),
    .i_pop      (w_pop),
    .o_data     (w_hb_data),
    .o_hb_valid (w_hb_valid)
  );

  // Next state, shifter contents and bit count; loads from the hold buffer pop it.
  always_comb begin
    w_state_nxt = r_state;
    w_sh_nxt    = r_sh;
    w_cnt_nxt   = r_cnt;
    w_pop       = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_hb_valid) begin
          w_sh_nxt    = w_hb_data;
          w_cnt_nxt   = '0;
          w_pop       = 1'b1;
          w_state_nxt = SHIFT;
        end else begin
          w_state_nxt = IDLE;
        end
      end
      SHIFT: begin
        if (i_bit_en) begin
          if (r_cnt == LAST_CNT) begin
            if (w_hb_valid) begin
              w_sh_nxt    = w_hb_data;
              w_cnt_nxt   = '0;
              w_pop       = 1'b1;
              w_state_nxt = SHIFT;
            end else begin
              w_state_nxt = IDLE;
            end
          end else begin
            if (LSB_FIRST) begin
              w_sh_nxt = r_sh >> 1;
            end else begin
              w_sh_nxt = r_sh << 1;
            end
            w_cnt_nxt = r_cnt + CNT_W'(1);
          end
        end else begin
          w_state_nxt = SHIFT;
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // State, shifter and bit-count registers.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state <= IDLE;
      r_sh    <= '0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_sh    <= w_sh_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Serial outputs decoded from the registered state only.
  always_comb begin
    o_ser_out   = IDLE_LEVEL;
    o_ser_valid = 1'b0;
    o_ser_last  = 1'b0;
    if (r_state == SHIFT) begin
      o_ser_valid = 1'b1;
      o_ser_last  = (r_cnt == LAST_CNT);
      o_ser_out   = LSB_FIRST ? r_sh[0] : r_sh[WIDTH-1];
    end else begin
      o_ser_out   = IDLE_LEVEL;
      o_ser_valid = 1'b0;
      o_ser_last  = 1'b0;
    end
    o_busy = (r_state == SHIFT) || w_hb_valid;
  end
endmodule
